// File: rtl/fft_out_serializer.sv
// Parallel-to-serial unloader for FFT result frames: captures a whole frame on
// the core's done strobe and streams it one complex sample per cycle.
`ifndef DATA_WID
`define DATA_WID 16
`endif
`ifndef FFT_LEN
`define FFT_LEN 64
`endif
`ifndef LOG2_FFT_LEN
`define LOG2_FFT_LEN 6
`endif

module fft_out_serializer #(
    parameter int DATA_WID     = `DATA_WID,
    parameter int FFT_LEN      = `FFT_LEN,
    parameter int LOG2_FFT_LEN = `LOG2_FFT_LEN,
    parameter bit BIT_REV      = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         val_i,
    input  logic [FFT_LEN*DATA_WID-1:0]  fft_data_re_i,
    input  logic [FFT_LEN*DATA_WID-1:0]  fft_data_im_i,
    input  logic                         ready_i,
    output logic                         val_o,
    output logic [DATA_WID-1:0]          fft_data_re_o,
    output logic [DATA_WID-1:0]          fft_data_im_o,
    output logic [LOG2_FFT_LEN-1:0]      idx_o,
    output logic                         sop_o,
    output logic                         eop_o,
    output logic                         busy_o,
    output logic                         ovf_o
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [LOG2_FFT_LEN-1:0] LAST_IDX = LOG2_FFT_LEN'(FFT_LEN - 1);

    state_t                        state, state_nxt;
    logic [FFT_LEN*DATA_WID-1:0]   frm_re, frm_im;
    logic [LOG2_FFT_LEN-1:0]       idx, idx_nxt, idx_rev, sel;
    logic                          ovf, ovf_nxt;
    logic                          capture, xfer, last;

    assign xfer = val_o & ready_i;
    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            ovf    <= 1'b0;
            frm_re <= '0;
            frm_im <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            ovf   <= ovf_nxt;
            if (capture) begin
                frm_re <= fft_data_re_i;
                frm_im <= fft_data_im_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ovf_nxt   = ovf;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (val_i) begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (xfer && last) begin
                    idx_nxt = '0;
                    // A strobe on the final transfer chains the next frame with no gap
                    if (val_i) capture = 1'b1;
                    else       state_nxt = IDLE;
                end else begin
                    if (xfer)  idx_nxt = idx + 1'b1;
                    if (val_i) ovf_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx_rev = '0;
        for (int b = 0; b < LOG2_FFT_LEN; b++)
            idx_rev[b] = idx[LOG2_FFT_LEN-1-b];
    end

    assign sel = BIT_REV ? idx_rev : idx;

    assign val_o         = (state == STREAM);
    assign busy_o        = val_o;
    assign idx_o         = idx;
    assign sop_o         = val_o & (idx == '0);
    assign eop_o         = val_o & last;
    assign ovf_o         = ovf;
    assign fft_data_re_o = frm_re[int'(sel)*DATA_WID +: DATA_WID];
    assign fft_data_im_o = frm_im[int'(sel)*DATA_WID +: DATA_WID];

endmodule
